// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// helpers that derive the cache geometry from the address split.
package ifu_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_DRAIN  = 2'd2
    } ifu_state_e;

    // Tag width: whatever is left above byte offset, word offset and index
    function automatic int ifu_tag_w(input int addr_w, input int index_w, input int off_w);
        return addr_w - index_w - off_w - 32'sd2;
    endfunction

    // Words per cache line
    function automatic int ifu_line_words(input int off_w);
        return 32'sd1 << off_w;
    endfunction

    // Derived widths for the default configuration (ADDR_W=32, INDEX_W=6, OFF_W=2)
    localparam int TAG_W      = ifu_tag_w(32'sd32, 32'sd6, 32'sd2);
    localparam int LINE_WORDS = ifu_line_words(32'sd2);

endpackage

// File: rtl/inst_fetch_unit_icache_array.sv
// Direct-mapped I-cache storage: per-line valid bits, tags and line data.
// Combinational read port, whole-line write port, valid bits cleared on rst.
module icache_array
    import ifu_pkg::*;
#(
    parameter int INDEX_W    = 6,
    parameter int TAG_W      = 24,
    parameter int LINE_WORDS = 4,
    parameter int INST_W     = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [INDEX_W-1:0]                    rd_idx,
    output logic                                  rd_valid,
    output logic [TAG_W-1:0]                      rd_tag,
    output logic [LINE_WORDS-1:0][INST_W-1:0]     rd_line,
    input  logic                                  wr_en,
    input  logic [INDEX_W-1:0]                    wr_idx,
    input  logic [TAG_W-1:0]                      wr_tag,
    input  logic [LINE_WORDS-1:0][INST_W-1:0]     wr_line
);

    localparam int LINES = 32'sd1 << INDEX_W;

    logic [LINES-1:0]                     valid_r;
    logic [TAG_W-1:0]                     tag_mem_r  [LINES];
    logic [LINE_WORDS-1:0][INST_W-1:0]    data_mem_r [LINES];

    // Valid bits: cleared on reset, set when a complete line is written
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {LINES{1'b0}};
        end else if (wr_en) begin
            valid_r[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage, written only as a whole line
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem_r[wr_idx]  <= wr_tag;
            data_mem_r[wr_idx] <= wr_line;
        end
    end

    assign rd_valid = valid_r[rd_idx];
    assign rd_tag   = tag_mem_r[rd_idx];
    assign rd_line  = data_mem_r[rd_idx];

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: direct-mapped I-cache lookup at pc, multi-beat line refill
// from the memory controller, static prediction from the predictor and
// redirect handling. Optional performance counters are built when the
// macro IFU_PERF_CNT_EN is defined; otherwise hit_cnt/miss_cnt read 0.
module inst_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                INDEX_W  = 6,
    parameter int                OFF_W    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    output logic              mc_req,
    output logic [ADDR_W-1:0] mc_addr,
    input  logic              mc_valid,
    input  logic [INST_W-1:0] mc_data,
    output logic [INST_W-1:0] pdc_inst,
    output logic [ADDR_W-1:0] pdc_pc,
    input  logic              pdc_jump,
    input  logic [ADDR_W-1:0] pdc_imm,
    input  logic              iq_full,
    output logic              iq_valid,
    output logic [INST_W-1:0] iq_inst,
    output logic [ADDR_W-1:0] iq_pc,
    output logic              iq_pred_jump,
    output logic [ADDR_W-1:0] iq_pred_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int CFG_TAG_W      = ifu_tag_w(ADDR_W, INDEX_W, OFF_W);
    localparam int CFG_LINE_WORDS = ifu_line_words(OFF_W);
    localparam int IDX_LSB        = OFF_W + 32'sd2;
    localparam int TAG_LSB        = IDX_LSB + INDEX_W;
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(3'd4);

    ifu_state_e                              state_r;
    ifu_state_e                              state_nxt_s;
    logic [ADDR_W-1:0]                       pc_r;
    logic [OFF_W-1:0]                        beat_r;
    logic [CFG_LINE_WORDS-1:0][INST_W-1:0]   line_buf_r;
    logic                                    mc_req_r;
    logic [ADDR_W-1:0]                       mc_addr_r;
    logic                                    iq_valid_r;
    logic [INST_W-1:0]                       iq_inst_r;
    logic [ADDR_W-1:0]                       iq_pc_r;
    logic                                    iq_pred_jump_r;
    logic [ADDR_W-1:0]                       iq_pred_pc_r;

    logic [INDEX_W-1:0]                      pc_idx_s;
    logic [CFG_TAG_W-1:0]                    pc_tag_s;
    logic [OFF_W-1:0]                        pc_off_s;
    logic [ADDR_W-1:0]                       line_base_s;
    logic                                    rd_valid_s;
    logic [CFG_TAG_W-1:0]                    rd_tag_s;
    logic [CFG_LINE_WORDS-1:0][INST_W-1:0]   rd_line_s;
    logic                                    hit_s;
    logic [INST_W-1:0]                       hit_word_s;
    logic [ADDR_W-1:0]                       pred_pc_s;
    logic                                    last_beat_s;
    logic                                    accept_beat_s;
    logic                                    wr_en_s;
    logic [CFG_LINE_WORDS-1:0][INST_W-1:0]   wr_line_s;
    logic                                    deliver_s;
    logic                                    start_refill_s;

    // Address split of the current pc
    assign pc_idx_s    = pc_r[TAG_LSB-1:IDX_LSB];
    assign pc_tag_s    = pc_r[ADDR_W-1:TAG_LSB];
    assign pc_off_s    = pc_r[IDX_LSB-1:2];
    assign line_base_s = {pc_r[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}};

    icache_array #(
        .INDEX_W    (INDEX_W),
        .TAG_W      (CFG_TAG_W),
        .LINE_WORDS (CFG_LINE_WORDS),
        .INST_W     (INST_W)
    ) u_icache (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pc_idx_s),
        .rd_valid (rd_valid_s),
        .rd_tag   (rd_tag_s),
        .rd_line  (rd_line_s),
        .wr_en    (wr_en_s),
        .wr_idx   (pc_idx_s),
        .wr_tag   (pc_tag_s),
        .wr_line  (wr_line_s)
    );

    assign hit_s      = rd_valid_s && (rd_tag_s == pc_tag_s);
    assign hit_word_s = rd_line_s[pc_off_s];
    assign pdc_pc     = pc_r;

    // Word offered to the predictor: cached word on a hit, zero otherwise
    always_comb begin
        if (hit_s) begin
            pdc_inst = hit_word_s;
        end else begin
            pdc_inst = {INST_W{1'b0}};
        end
    end

    // Predicted next pc, wrapping modulo 2**ADDR_W
    always_comb begin
        if (pdc_jump) begin
            pred_pc_s = pc_r + pdc_imm;
        end else begin
            pred_pc_s = pc_r + WORD_STEP;
        end
    end

    // The pc is held during a refill, so pc_idx/pc_tag name the line being filled.
    // A redirect in the final-beat cycle suppresses the write.
    assign last_beat_s   = (beat_r == {OFF_W{1'b1}});
    assign accept_beat_s = (state_r == ST_REFILL) && mc_valid && !redirect;
    assign wr_en_s       = !rst && rdy && accept_beat_s && last_beat_s;

    // Completed line: buffered beats plus the word arriving this cycle
    always_comb begin
        wr_line_s         = line_buf_r;
        wr_line_s[beat_r] = mc_data;
    end

    // Next-state and per-cycle fetch decisions; redirect outranks everything
    always_comb begin
        state_nxt_s    = state_r;
        deliver_s      = 1'b0;
        start_refill_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (redirect) begin
                    state_nxt_s = ST_IDLE;
                end else if (iq_full) begin
                    state_nxt_s = ST_IDLE;
                end else if (hit_s) begin
                    deliver_s = 1'b1;
                end else begin
                    start_refill_s = 1'b1;
                    state_nxt_s    = ST_REFILL;
                end
            end
            ST_REFILL: begin
                // A beat returning in the redirect cycle leaves nothing outstanding
                if (redirect) begin
                    if (mc_valid) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end else if (mc_valid && last_beat_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REFILL;
                end
            end
            ST_DRAIN: begin
                if (mc_valid) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else if (rdy) begin
            state_r <= state_nxt_s;
        end
    end

    // Fetch pc: redirect first, then advance to the predicted pc on delivery
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (rdy) begin
            if (redirect) begin
                pc_r <= redirect_pc;
            end else if (deliver_s) begin
                pc_r <= pred_pc_s;
            end
        end
    end

    // Memory request, beat counter and line buffer; request is live in REFILL and DRAIN
    always_ff @(posedge clk) begin
        if (rst) begin
            mc_req_r   <= 1'b0;
            mc_addr_r  <= {ADDR_W{1'b0}};
            beat_r     <= {OFF_W{1'b0}};
            line_buf_r <= {(CFG_LINE_WORDS*INST_W){1'b0}};
        end else if (rdy) begin
            mc_req_r <= (state_nxt_s == ST_REFILL) || (state_nxt_s == ST_DRAIN);
            if (start_refill_s) begin
                mc_addr_r <= line_base_s;
                beat_r    <= {OFF_W{1'b0}};
            end else if (accept_beat_s) begin
                line_buf_r[beat_r] <= mc_data;
                if (!last_beat_s) begin
                    mc_addr_r <= mc_addr_r + WORD_STEP;
                    beat_r    <= beat_r + OFF_W'(1'b1);
                end
            end
        end
    end

    // Instruction queue outputs: one-cycle valid pulse per delivered word
    always_ff @(posedge clk) begin
        if (rst) begin
            iq_valid_r     <= 1'b0;
            iq_inst_r      <= {INST_W{1'b0}};
            iq_pc_r        <= {ADDR_W{1'b0}};
            iq_pred_jump_r <= 1'b0;
            iq_pred_pc_r   <= {ADDR_W{1'b0}};
        end else if (rdy) begin
            iq_valid_r <= deliver_s;
            if (deliver_s) begin
                iq_inst_r      <= hit_word_s;
                iq_pc_r        <= pc_r;
                iq_pred_jump_r <= pdc_jump;
                iq_pred_pc_r   <= pred_pc_s;
            end
        end
    end

    assign mc_req       = mc_req_r;
    assign mc_addr      = mc_addr_r;
    assign iq_valid     = iq_valid_r;
    assign iq_inst      = iq_inst_r;
    assign iq_pc        = iq_pc_r;
    assign iq_pred_jump = iq_pred_jump_r;
    assign iq_pred_pc   = iq_pred_pc_r;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] hit_cnt_r;
    logic [31:0] miss_cnt_r;

    // Hit/miss counters, wrapping at 2**32
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else if (rdy) begin
            if (deliver_s) begin
                hit_cnt_r <= hit_cnt_r + 32'd1;
            end
            if (start_refill_s) begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_r;
    assign miss_cnt = miss_cnt_r;
`else
    assign hit_cnt  = 32'd0;
    assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: a table of directed fetch runs,
// hand-written corner sequences and a randomized run, all scored against a
// program-order reference of the fetch stream and a bench-side memory model.
module tb_inst_fetch_unit;

`ifdef IFU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, rdy, mc_req, mc_valid, pdc_jump, iq_full, iq_valid, iq_pred_jump, redirect;
    logic [31:0] mc_addr, mc_data, pdc_inst, pdc_pc, pdc_imm, iq_inst, iq_pc, iq_pred_pc;
    logic [31:0] redirect_pc, hit_cnt, miss_cnt;

    int          pmode = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          mc_cnt = 0;
    int          mc_lat = 3;
    int          deliv_cnt = 0;
    logic [31:0] m_pc = 32'h0;
    logic        prev_iq_valid = 1'b0;
    logic [31:0] dq[$];
    logic [31:0] mcq[$];

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .mc_req(mc_req), .mc_addr(mc_addr), .mc_valid(mc_valid), .mc_data(mc_data),
        .pdc_inst(pdc_inst), .pdc_pc(pdc_pc), .pdc_jump(pdc_jump), .pdc_imm(pdc_imm),
        .iq_full(iq_full), .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc),
        .iq_pred_jump(iq_pred_jump), .iq_pred_pc(iq_pred_pc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Memory contents: never zero, distinct per word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h00FF} | 32'h1;
    endfunction

    // Predictor modes: 0 never taken, 1 loop at 0x8 back to 0, 2 hashed branches
    function automatic logic jump_of(input logic [31:0] pc, input int m);
        if (m == 1) return (pc == 32'h8);
        if (m == 2) return (((pc >> 2) % 32'd7) == 32'd3);
        return 1'b0;
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] pc, input int m);
        if (!jump_of(pc, m)) return 32'hDEAD_0000;
        if (m == 1) return 32'h0 - pc;
        return (((pc * 32'd5) + 32'h40) & 32'h7FC) - pc;
    endfunction

    function automatic logic [31:0] pred_of(input logic [31:0] pc, input int m);
        return jump_of(pc, m) ? pc + imm_of(pc, m) : pc + 32'd4;
    endfunction

    always_comb begin
        pdc_jump = jump_of(pdc_pc, pmode);
        pdc_imm  = imm_of(pdc_pc, pmode);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: memory-controller model drives mc_valid, then the stream is scored
    task automatic step();
        logic        req_s;
        logic [31:0] addr_s;
        @(negedge clk);
        req_s  = mc_req;
        addr_s = mc_addr;
        if (!rst && rdy && req_s && mc_cnt >= mc_lat) begin
            mc_valid = 1'b1;
            mc_data  = mem_word(addr_s);
        end else begin
            mc_valid = 1'b0;
            mc_data  = 32'h0;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            mc_cnt    = 0;
            m_pc      = 32'h0;
            deliv_cnt = 0;
            chk("rst_iq_valid", 32'(iq_valid), 32'd0);
            chk("rst_mc_req", 32'(mc_req), 32'd0);
            chk("rst_pc", pdc_pc, 32'h0);
        end else if (!rdy) begin
            chk("frz_pc", pdc_pc, m_pc);
            chk("frz_iq_valid", 32'(iq_valid), 32'(prev_iq_valid));
            chk("frz_mc_req", 32'(mc_req), 32'(req_s));
        end else begin
            if (mc_valid) begin
                mc_cnt = 0;
                mcq.push_back(addr_s);
            end else if (req_s) begin
                mc_cnt++;
            end
            if (redirect) begin
                chk("redir_iq_valid", 32'(iq_valid), 32'd0);
                m_pc = redirect_pc;
            end else begin
                if (iq_full) chk("full_no_iq", 32'(iq_valid), 32'd0);
                if (iq_valid) begin
                    chk("iq_pc", iq_pc, m_pc);
                    chk("iq_inst", iq_inst, mem_word(m_pc));
                    chk("iq_pred_jump", 32'(iq_pred_jump), 32'(jump_of(m_pc, pmode)));
                    chk("iq_pred_pc", iq_pred_pc, pred_of(m_pc, pmode));
                    dq.push_back(iq_pc);
                    m_pc = pred_of(m_pc, pmode);
                    deliv_cnt++;
                end
            end
            chk("pc", pdc_pc, m_pc);
            if (mc_req) chk("mc_align", 32'(mc_addr[1:0]), 32'd0);
            if (pdc_inst != 32'h0) chk("pdc_inst", pdc_inst, mem_word(pdc_pc));
        end
        prev_iq_valid = iq_valid;
        mc_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; iq_full = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        step();
        rst = 1'b0;
        dq.delete();
        mcq.delete();
    endtask

    task automatic run_until(input int n, input int budget);
        int c = 0;
        while (dq.size() < n && c < budget) begin
            step();
            c++;
        end
        if (dq.size() < n) chk("deliver_timeout", 32'(dq.size()), 32'(n));
    endtask

    task automatic wait_mc(input int n, input int budget);
        int c = 0;
        while (mcq.size() < n && c < budget) begin
            step();
            c++;
        end
        if (mcq.size() < n) chk("mc_timeout", 32'(mcq.size()), 32'(n));
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect = 1'b1;
        redirect_pc = pc;
        step();
        redirect = 1'b0;
    endtask

    typedef struct {
        logic [31:0] start;
        int          mode;
        int          n;
        logic [31:0] pcs [6];
        logic [31:0] misses;
    } vec_t;

    vec_t tv [5];

    initial begin
        mc_valid = 1'b0; mc_data = 32'h0;
        rst = 1'b1; rdy = 1'b1; iq_full = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

        tv[0].start = 32'h0;        tv[0].mode = 0; tv[0].n = 4; tv[0].misses = 32'd1;
        tv[0].pcs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h0};
        tv[1].start = 32'h0;        tv[1].mode = 1; tv[1].n = 6; tv[1].misses = 32'd1;
        tv[1].pcs = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4, 32'h8};
        tv[2].start = 32'h100;      tv[2].mode = 0; tv[2].n = 6; tv[2].misses = 32'd2;
        tv[2].pcs = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114};
        tv[3].start = 32'h3F8;      tv[3].mode = 0; tv[3].n = 4; tv[3].misses = 32'd2;
        tv[3].pcs = '{32'h3F8, 32'h3FC, 32'h400, 32'h404, 32'h0, 32'h0};
        tv[4].start = 32'hFFFF_FFF8; tv[4].mode = 0; tv[4].n = 4; tv[4].misses = 32'd2;
        tv[4].pcs = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h0, 32'h0};

        // Reset state of every output
        do_reset();
        chk("rst_iq_pc", iq_pc, 32'h0);
        chk("rst_iq_inst", iq_inst, 32'h0);
        chk("rst_iq_pred_pc", iq_pred_pc, 32'h0);
        chk("rst_mc_addr", mc_addr, 32'h0);
        chk("rst_hit_cnt", hit_cnt, 32'h0);
        chk("rst_miss_cnt", miss_cnt, 32'h0);

        // Cold start: four beats at 0x0..0xC, then four deliveries
        pmode = 0; mc_lat = 3;
        run_until(4, 200);
        for (int j = 0; j < 4; j++)
            chk("cold_beat_addr", (j < mcq.size()) ? mcq[j] : 32'hxxxx_xxxx, 32'(j * 4));

        // Table of directed fetch runs from reset
        for (int i = 0; i < 5; i++) begin
            do_reset();
            pmode = tv[i].mode;
            mc_lat = 3;
            if (tv[i].start != 32'h0) do_redirect(tv[i].start);
            run_until(tv[i].n, 400);
            for (int j = 0; j < tv[i].n; j++)
                chk("tbl_pc", (j < dq.size()) ? dq[j] : 32'hxxxx_xxxx, tv[i].pcs[j]);
            chk("tbl_miss_cnt", miss_cnt, PERF ? tv[i].misses : 32'd0);
            chk("tbl_hit_cnt", hit_cnt, PERF ? 32'(tv[i].n) : 32'd0);
        end

        // iq_full mid-line holds pc and resumes without duplicates
        do_reset(); pmode = 0;
        run_until(2, 200);
        iq_full = 1'b1;
        repeat (5) step();
        chk("full_pc_held", pdc_pc, 32'h8);
        chk("full_no_new", 32'(dq.size()), 32'd2);
        iq_full = 1'b0;
        run_until(3, 50);
        chk("full_resume_pc", (dq.size() > 2) ? dq[2] : 32'hxxxx_xxxx, 32'h8);

        // Redirect during beat 1 drains the outstanding read and drops line 0
        do_reset(); pmode = 0; mc_lat = 3;
        wait_mc(1, 50);
        do_redirect(32'h100);
        chk("drain_req", 32'(mc_req), 32'd1);
        chk("drain_addr", mc_addr, 32'h4);
        wait_mc(2, 50);
        chk("drain_release", 32'(mc_req), 32'd0);
        step();
        chk("redir_refill_req", 32'(mc_req), 32'd1);
        chk("redir_refill_addr", mc_addr, 32'h100);
        run_until(1, 200);
        do_redirect(32'h0);
        step();
        chk("line0_invalid_req", 32'(mc_req), 32'd1);
        chk("line0_invalid_addr", mc_addr, 32'h0);

        // Conflicting line 0x400 replaces line 0
        do_reset(); pmode = 0;
        run_until(4, 200);
        do_redirect(32'h400);
        run_until(5, 300);
        chk("conflict_fetch", (dq.size() > 4) ? dq[4] : 32'hxxxx_xxxx, 32'h400);
        do_redirect(32'h0);
        step();
        chk("conflict_miss_req", 32'(mc_req), 32'd1);
        chk("conflict_miss_addr", mc_addr, 32'h0);

        // Reset in the middle of a refill invalidates every line
        do_reset(); pmode = 0;
        run_until(4, 200);
        for (int c = 0; c < 20 && !mc_req; c++) step();
        step(); step();
        chk("mid_refill_req", 32'(mc_req), 32'd1);
        rst = 1'b1;
        step();
        chk("rst_refill_iq_valid", 32'(iq_valid), 32'd0);
        rst = 1'b0;
        step();
        chk("rst_cold_miss_req", 32'(mc_req), 32'd1);
        chk("rst_cold_miss_addr", mc_addr, 32'h0);

        // Randomized run: stalls, queue back-pressure, redirects, variable latency
        do_reset(); pmode = 2;
        for (int c = 0; c < 4000; c++) begin
            rdy = ($urandom_range(0, 9) != 0);
            iq_full = ($urandom_range(0, 4) == 0);
            redirect = ($urandom_range(0, 49) == 0);
            redirect_pc = {19'd0, 11'($urandom_range(0, 2047)), 2'b00};
            mc_lat = $urandom_range(0, 4);
            step();
        end
        rdy = 1'b1; iq_full = 1'b0; redirect = 1'b0;
        chk("rand_progress", 32'(deliv_cnt > 200), 32'd1);
        chk("rand_hit_cnt", hit_cnt, PERF ? 32'(deliv_cnt) : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
